matrix_loader: RTL
==================

# matrix_loader

Upstream feeder for the 3x3 determinant unit. Accepts nine signed 8-bit matrix elements over a valid/ready byte stream and writes them row-major into a 16x8 matrix store at a caller-chosen base address. It then issues a one-cycle start pulse and the start address to the determinant top level, and holds off new loads until that unit reports finish. The store's combinational read port has the same shape as the 16x8 data ROM and replaces it directly.

## Interface
Parameters:
- BW, 8, element width in bits
- N, 16, store depth; address width is $clog2(N) = 4
- ELEMS, 9, elements per matrix

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- load_go  in  1  request a new load; sampled only in IDLE
- base_address  in  4  first write address; latched when load_go is accepted
- data_valid  in  1  producer has a byte on data_in
- data_in  in  BW  matrix element, row-major a11..a33
- data_ready  out  1  loader accepts data_in this cycle
- rd_addr  in  4  read address from the determinant top level
- rd_data  out  BW  combinational store[rd_addr]
- start1  out  1  one-cycle start pulse to the determinant top level
- start_address  out  4  latched base, stable from accept until next accept
- det_finish  in  1  finish from the determinant top level
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE
  - LOAD: data_ready = 1
  - KICK: start1 = 1
  - WAIT: waits for det_finish
- IDLE -> LOAD when load_go = 1. On that edge, latch base_address into start_address and clear the element count to 0.
- LOAD:
  - A transfer is data_valid & data_ready.
  - On each transfer, store[start_address + count] <= data_in and count <= count + 1.
  - The address sum is taken modulo 16, so it wraps.
  - When the transfer with count = 8 occurs, go to KICK.
  - data_valid low means hold: no write and no count change.
- KICK -> WAIT unconditionally, after exactly one cycle.
- WAIT -> IDLE when det_finish = 1. det_finish is ignored in all other states.
- load_go outside IDLE is ignored. It is not queued.
- Reads are unrestricted in every state. A read of an address being written returns the old value until the write edge.
- Only the nine target locations are written. All other locations keep their contents.

## Timing
- Reset values:
  - state IDLE, count 0
  - data_ready 0, start1 0, busy 0
  - start_address 0
  - all 16 store locations 0
- rst asserted mid-load or in WAIT aborts the operation. Partially written data is cleared to 0 by the store reset.
- load_go high in cycle t puts the block in LOAD at t+1, with data_ready = 1 in t+1.
- Minimum load time is 9 cycles when data_valid is held high.
- If the 9th transfer is at cycle t:
  - start1 = 1 in cycle t+1 only.
  - data_ready = 0 from t+1 onward.
  - The 9th write is visible on rd_data from t+1.
- det_finish high in cycle w (state WAIT) puts the block in IDLE at w+1. A load_go in w+1 is accepted.
- start1 is never high for more than one consecutive cycle.

## Structure
- Shared package `matrix_pkg`:
  - state enum {IDLE, LOAD, KICK, WAIT}
  - constants BW = 8, N = 16, ELEMS = 9
  - address width localparam
- Sub-module `matrix_ram`, instantiated once:
  - 16x8 register array
  - synchronous write: we, waddr, wdata
  - synchronous reset-to-zero
  - combinational read: rd_addr -> rd_data
- The FSM, element counter and address adder live in matrix_loader.

## Test plan
- Basic load: reset; load_go with base = 0; stream 1..9 with data_valid held high.
  - Required: nine ready cycles, then start1 for exactly one cycle.
  - Required: rd_data at addresses 0..8 = 1..9; addresses 9..15 = 0.
- Wrap: base = 12, elements 0x11..0x19.
  - Required: addresses 12,13,14,15,0,1,2,3,4 hold 0x11..0x19.
  - Required: start_address = 12.
- Stalls: data_valid toggles 1,0,0,1,... over a 9-element load.
  - Required: writes only on valid cycles; start1 one cycle after the 9th transfer.
  - Required: no extra writes; counts match.
- Ignored requests: load_go pulsed during LOAD and during WAIT.
  - Required: base unchanged, no restart.
  - Required: det_finish in WAIT returns to IDLE next cycle.
  - Required: a new load_go is accepted afterwards.
- Reset mid-load: rst after 4 transfers.
  - Required: next cycle busy = 0, data_ready = 0, all locations read 0, no start1.
- Back-to-back: det_finish and load_go (base = 3) on adjacent cycles.
  - Required: second load starts the cycle after IDLE is reached.
  - Required: start_address = 3; values at addresses 3..11 are negative, e.g. 0x80 and 0xFF stored exactly.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and sizing for the matrix loader and its backing store.
package matrix_pkg;

  localparam int unsigned BW    = 8;
  localparam int unsigned N     = 16;
  localparam int unsigned ELEMS = 9;
  localparam int unsigned AW    = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT
  } state_e;

endpackage

// File: rtl/matrix_ram.sv
// N x BW register array: synchronous write and reset-to-zero, combinational read.
module matrix_ram #(
  parameter int unsigned BW = 8,
  parameter int unsigned N  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] waddr_i,
  input  logic [BW-1:0]        wdata_i,
  input  logic [$clog2(N)-1:0] raddr_i,
  output logic [BW-1:0]        rdata_o
);

  logic [BW-1:0] mem_q [N];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/matrix_loader.sv
// Streams nine row-major matrix elements into the store at a chosen base,
// then kicks the determinant unit and waits for its finish.
module matrix_loader #(
  parameter int unsigned BW    = matrix_pkg::BW,
  parameter int unsigned N     = matrix_pkg::N,
  parameter int unsigned ELEMS = matrix_pkg::ELEMS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_go,
  input  logic [$clog2(N)-1:0] base_address,
  input  logic                 data_valid,
  input  logic [BW-1:0]        data_in,
  output logic                 data_ready,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [BW-1:0]        rd_data,
  output logic                 start1,
  output logic [$clog2(N)-1:0] start_address,
  input  logic                 det_finish,
  output logic                 busy
);

  import matrix_pkg::*;

  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned CNT_W  = $clog2(ELEMS);

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   start_address_q;
  logic                data_ready_q;
  logic                start1_q;
  logic                busy_q;

  logic                xfer;
  logic [ADDR_W-1:0]   waddr;

  assign xfer  = data_valid & data_ready_q;
  // Address sum truncates to ADDR_W bits so a high base wraps to the bottom.
  assign waddr = start_address_q + ADDR_W'(count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      start_address_q <= '0;
      data_ready_q    <= 1'b0;
      start1_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      start1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_go) begin
            state_q         <= LOAD;
            start_address_q <= base_address;
            count_q         <= '0;
            data_ready_q    <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            count_q <= count_q + 1'b1;
            if (count_q == CNT_W'(ELEMS - 1)) begin
              state_q      <= KICK;
              data_ready_q <= 1'b0;
              start1_q     <= 1'b1;
            end
          end
        end
        KICK: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (det_finish) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  matrix_ram #(
    .BW (BW),
    .N  (N)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (xfer),
    .waddr_i (waddr),
    .wdata_i (data_in),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign data_ready    = data_ready_q;
  assign start1        = start1_q;
  assign start_address = start_address_q;
  assign busy          = busy_q;

endmodule
